// File: rtl/score_digit_renderer.sv
// Binary score -> 4 BCD digits (sequential double-dabble), rendered as an 8x8-font text field.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (units always shown).
module score_digit_renderer #(
  parameter int X0          = 16,
  parameter int Y0          = 16,
  parameter int SCALE_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  output logic        conv_done,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [3:0]  rom_digit,
  output logic [2:0]  rom_row,
  input  logic [7:0]  rom_bitmap,
  output logic        pixel_on
);

  localparam int GLYPH_W = 8 << SCALE_SHIFT;
  localparam int FIELD_W = 4 * GLYPH_W;
  localparam int FIELD_H = GLYPH_W;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t      r_state;
  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_bit_cnt;
  logic [3:0]  r_digit [4];   // [3] = thousands .. [0] = units
  logic [15:0] w_bcd_adj;

  // NOTE: every variable driven in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < 4; n++) begin
      if (r_bcd[n*4 +: 4] >= 4'd5) w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      value_ready <= 1'b1;
      conv_done   <= 1'b0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_bit_cnt   <= '0;
      // NOTE: the digit registers are reset because the display must read 0000 straight out of reset.
      for (int n = 0; n < 4; n++) r_digit[n] <= '0;
    end else begin
      conv_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (value_valid) begin
            r_bin       <= (value > 14'd9999) ? 14'd9999 : value;
            r_bcd       <= '0;
            r_bit_cnt   <= '0;
            value_ready <= 1'b0;
            r_state     <= S_CONV;
          end
        end
        S_CONV: begin
          r_bcd     <= {w_bcd_adj[14:0], r_bin[13]};
          r_bin     <= {r_bin[12:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd13) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          for (int n = 0; n < 4; n++) r_digit[n] <= r_bcd[n*4 +: 4];
          conv_done   <= 1'b1;
          value_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [9:0] w_dx, w_dy;
  logic       w_in_field;
  logic [1:0] w_idx, w_sel;
  logic [2:0] w_col;
  logic [3:0] w_blank;

  assign w_dx       = pixel_x - 10'(X0);
  assign w_dy       = pixel_y - 10'(Y0);
  assign w_in_field = (pixel_x >= 10'(X0)) && (w_dx < 10'(FIELD_W)) &&
                      (pixel_y >= 10'(Y0)) && (w_dy < 10'(FIELD_H));
  assign w_idx      = 2'(w_dx >> (3 + SCALE_SHIFT));
  assign w_col      = 3'(w_dx >> SCALE_SHIFT);
  assign w_sel      = 2'd3 - w_idx;   // slot 0 (leftmost) shows the thousands digit
  assign rom_row    = 3'd7 - 3'(w_dy >> SCALE_SHIFT);

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank[3] = (r_digit[3] == 4'd0);
  assign w_blank[2] = w_blank[3] && (r_digit[2] == 4'd0);
  assign w_blank[1] = w_blank[2] && (r_digit[1] == 4'd0);
  assign w_blank[0] = 1'b0;
`else
  assign w_blank = '0;
`endif

  assign rom_digit = (w_in_field && !w_blank[w_sel]) ? r_digit[w_sel] : 4'd15;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pixel_on <= 1'b0;
    else     pixel_on <= w_in_field & rom_bitmap[3'd7 - w_col];
  end

endmodule

// File: doc/score_digit_renderer.md
Name: score_digit_renderer

Overview:
Converts a binary score into four BCD digits with a sequential double-dabble engine, then renders them as an 8x8-font text field on the VGA raster. Sits directly upstream of digit_font_rom: per pixel it drives the ROM's digit/row inputs and consumes the returned bitmap_row, producing a registered pixel_on for the colour mixer. Displayed digits change only on conversion commit, so the field never shows partial values.

Parameters:
X0, 16, left pixel column of the digit field
Y0, 16, top pixel row of the digit field
SCALE_SHIFT, 1, glyph magnification = 2^SCALE_SHIFT; each font cell is (8<<SCALE_SHIFT) px square

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
value  in  14  binary score; values above 9999 clamp to 9999
value_valid  in  1  request to convert value; accepted only when value_ready=1
value_ready  out  1  converter idle, will accept value_valid
conv_done  out  1  one-cycle pulse when new digits are committed to the display
pixel_x  in  10  current raster column
pixel_y  in  10  current raster row
rom_digit  out  4  digit code to font ROM (15 = blank, ROM returns all-zero row)
rom_row  out  3  font row to ROM; row 7 = top line of glyph
rom_bitmap  in  8  bitmap_row from ROM; bit 7 = leftmost pixel
pixel_on  out  1  registered: current pixel lies on a lit glyph pixel

Behaviour:
- Reset (async, immediate): state IDLE, value_ready=1, conv_done=0, pixel_on=0, shift/BCD registers 0, displayed digits 0,0,0,0. Reset mid-conversion aborts it; display shows 0000.
- FSM IDLE -> CONV -> COMMIT -> IDLE.
- IDLE: value_ready=1. On edge E0 with value_valid=1: latch min(value,9999) into 14-bit shift reg, clear 16-bit BCD reg, bit counter=0, go CONV.
- CONV: value_ready=0. Edges E1..E14: every BCD nibble >=5 gets +3, then shift {bcd,bin} left 1. After the 14th shift, go COMMIT.
- COMMIT: edge E15 copies the BCD nibbles to displayed digits (d3=thousands..d0=units), sets conv_done=1 for one cycle (E15..E16), returns to IDLE. value_ready is high from E15. Acceptance to commit = 15 cycles.
- value_valid while value_ready=0 is ignored, not queued.
- Pixel path, combinational to the ROM: dx=pixel_x-X0, dy=pixel_y-Y0. in_field = pixel_x>=X0 && dx<(32<<SCALE_SHIFT) && pixel_y>=Y0 && dy<(8<<SCALE_SHIFT).
- idx = dx>>(3+SCALE_SHIFT), 0 = leftmost = d3. col = (dx>>SCALE_SHIFT)&7. rom_row = 7-((dy>>SCALE_SHIFT)&7).
- rom_digit = displayed digit[idx] when in_field, else 15.
- pixel_on registered: next pixel_on = in_field & rom_bitmap[7-col]. Latency is 1 clk from pixel_x/pixel_y.
- Display updates only at COMMIT, so the raster reads consistent digits even when COMMIT lands mid-frame.

Optional Feature:
LEADING_ZERO_BLANK_EN: when defined, leading zero digits (d3, then d2, then d1, while all more-significant digits are also 0) drive rom_digit=15 and render blank. d0 is always shown, so 0 renders as a single "0". When undefined, all four digits always render, zero-padded ("0042").

Test Plan:
- value=1234, valid pulse at E0 -> value_ready low E1..E14; conv_done high exactly E15..E16; displayed digits 1,2,3,4; value_ready high from E15.
- value=12000 -> clamps; displayed 9,9,9,9.
- Conversion of 5678 in progress, second valid with 42 at E5 -> ignored; display becomes 5,6,7,8. Next valid with 42 after ready -> 0,0,4,2.
- Display 0000, SCALE_SHIFT=1, pixel (X0,Y0) -> rom_digit=0, rom_row=7; ROM returns 00111100; pixel_on=0 next cycle. Pixel (X0+4,Y0) -> pixel_on=1. Pixel (X0-1,Y0) or (X0+64,Y0) -> rom_digit=15, pixel_on=0.
- Assert rst at E7 of converting 9999 -> same-cycle outputs reset; display 0000; no conv_done; value_ready=1 after release.
- LEADING_ZERO_BLANK_EN defined, value=42 -> pixels in digit slots 0-1 give rom_digit=15 and pixel_on=0; slots 2-3 give 4 and 2. With value=0, only slot 3 is lit.
